ahbl_sram_slave: RTL and testbench

- Single-port word-organised AHB-Lite SRAM slave.
- Sits directly downstream of the Ibex-to-AHB-Lite bridge on either the instruction or the data AHB port, and serves as the memory model/target for the core.
- Accepts NONSEQ/SEQ transfers with configurable wait states and byte-lane writes.
- Returns the two-cycle ERROR response for out-of-range, misaligned or oversize accesses.

---
 rtl/ahbl_sram_slave.sv | 131 +++++++++++++
 tb/tb_ahbl_sram_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slave.sv
// Word-organised AHB-Lite SRAM target: byte-lane writes, programmable OKAY wait states,
// two-cycle ERROR for out-of-range/misaligned/oversize accesses; back-to-back transfers run bubble-free.
module ahbl_sram_slave #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel,
    input  logic [WIDTH-1:0] haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic [3:0]       hprot,
    input  logic             hmastlock,
    input  logic             hready,
    input  logic [WIDTH-1:0] hwdata,
    output logic             hreadyout,
    output logic [WIDTH-1:0] hrdata,
    output logic             hresp
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [AW+1:0]    addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [3:0]       be;
    logic             can_accept, accept, addr_err;
    logic             unused_sigs;

    assign unused_sigs = ^{htrans[0], hburst, hprot, hmastlock};

    // Only cycles whose data phase is completing may take a new address phase.
    assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept     = can_accept & hsel & htrans[1] & hready;

    always_comb begin
        addr_err = 1'b0;
        if ({2'b00, haddr[WIDTH-1:2]} >= WIDTH'(DEPTH))  addr_err = 1'b1;
        if (hsize > 3'd2)                                addr_err = 1'b1;
        if (hsize == 3'd1 && haddr[0])                   addr_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)        addr_err = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else if (accept) begin
            addr_q  <= haddr[AW+1:0];
            write_q <= hwrite;
            size_q  <= hsize;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = S_DATA;
            end
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (!accept) begin
                    state_nxt = S_IDLE;
                end else if (addr_err) begin
                    state_nxt = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WS4;
                end else begin
                    state_nxt = S_DATA;
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        case (state)
            S_WAIT: hreadyout = 1'b0;
            S_DATA: if (!write_q) hrdata = mem[addr_q[AW+1:2]];
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Reset forces state to IDLE asynchronously, so an abandoned write never reaches here.
    always_ff @(posedge clk) begin
        if (state == S_DATA && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: one zero-wait and one two-wait instance share the
// address/data bus; expected responses are queued at acceptance and checked by a monitor.
module tb_ahbl_sram_slave;
    typedef struct packed {
        logic [31:0] rdata;
        logic        resp;
        logic [3:0]  waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsel0 = 1'b0, hsel1 = 1'b0;
    logic        hwrite = 1'b0;
    logic        other_rdy = 1'b1;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = '0;
    logic        hmastlock = 1'b0;
    logic        hreadyout0, hresp0, hreadyout1, hresp1;
    logic        hready0, hready1;
    logic [31:0] hrdata0, hrdata1;

    int   nchk = 0;
    int   npass = 0;
    int   lat_d;
    int   lat;
    exp_t q0[$];
    exp_t q1[$];
    bit   act[2];
    int   nwait[2];
    int   nwresp[2];
    logic        mro, mrs, msl, mhr;
    logic [31:0] mrd;
    exp_t        me;

    assign hready0 = hreadyout0 & other_rdy;
    assign hready1 = hreadyout1;

    always #5 clk = ~clk;

    ahbl_sram_slave #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hready(hready0), .hwdata(hwdata),
        .hreadyout(hreadyout0), .hrdata(hrdata0), .hresp(hresp0)
    );

    ahbl_sram_slave #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hready(hready1), .hwdata(hwdata),
        .hreadyout(hreadyout1), .hrdata(hrdata1), .hresp(hresp1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    endtask

    // Monitor: tracks each data phase, counts stall cycles, compares on completion.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                mro = (i == 0) ? hreadyout0 : hreadyout1;
                mrs = (i == 0) ? hresp0 : hresp1;
                mrd = (i == 0) ? hrdata0 : hrdata1;
                msl = (i == 0) ? hsel0 : hsel1;
                mhr = (i == 0) ? hready0 : hready1;
                if (rst) begin
                    act[i] = 1'b0;
                end else begin
                    if (act[i]) begin
                        if (!mro) begin
                            nwait[i]++;
                            if (mrs) nwresp[i]++;
                        end else begin
                            act[i] = 1'b0;
                            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                                nchk++;
                                $display("FAIL dut%0d response: got hresp=%0b hrdata=0x%08h, expected no transfer", i, mrs, mrd);
                            end else begin
                                if (i == 0) me = q0.pop_front();
                                else        me = q1.pop_front();
                                chk($sformatf("dut%0d wait cycles", i), 32'(nwait[i]), 32'(me.waits));
                                chk($sformatf("dut%0d stall hresp cycles", i), 32'(nwresp[i]),
                                    32'(me.resp ? me.waits : 4'd0));
                                chk($sformatf("dut%0d hresp", i), 32'(mrs), 32'(me.resp));
                                chk($sformatf("dut%0d hrdata", i), mrd, me.rdata);
                            end
                        end
                    end
                    if (msl && htrans[1] && mhr) begin
                        act[i]    = 1'b1;
                        nwait[i]  = 0;
                        nwresp[i] = 0;
                    end
                end
            end
        end
    end

    task automatic xfer(input int sel, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdat, input bit err, input logic [31:0] rexp,
                        input bit push, output int latency);
        bit   ok;
        exp_t e;
        hsel0   = (sel == 0);
        hsel1   = (sel == 1);
        haddr   = addr;
        htrans  = 2'b10;
        hwrite  = wr;
        hsize   = sz;
        latency = 0;
        ok      = 1'b0;
        while (!ok && latency < 50) begin
            @(negedge clk);
            ok = (sel == 0) ? hready0 : hready1;
            @(posedge clk);
            latency++;
        end
        #1;
        if (!ok) begin
            nchk++;
            $display("FAIL dut%0d accept timeout: got no hready in %0d cycles, expected acceptance", sel, latency);
        end else if (push) begin
            e.rdata = (wr || err) ? 32'h0 : rexp;
            e.resp  = err;
            e.waits = err ? 4'd1 : ((sel == 0) ? 4'd0 : 4'd2);
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        hwdata = wdat;
    endtask

    task automatic wr(input int sel, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d, input bit err);
        xfer(sel, 1'b1, sz, a, d, err, 32'h0, 1'b1, lat_d);
    endtask

    task automatic rd(input int sel, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] x, input bit err);
        xfer(sel, 1'b0, sz, a, 32'h0, err, x, 1'b1, lat_d);
    endtask

    task automatic idle();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // One address phase on dut0 that must not be accepted, followed by a would-be data phase.
    task automatic noacc(input string nm, input bit s, input logic [1:0] tr, input bit ordy,
                         input logic [31:0] addr, input logic [31:0] wdat);
        hsel0 = s; htrans = tr; hwrite = 1'b1; hsize = 3'd2; haddr = addr; other_rdy = ordy;
        @(posedge clk); #1;
        hwdata = wdat; hsel0 = 1'b0; htrans = 2'b00; other_rdy = 1'b1;
        @(negedge clk);
        chk({nm, " hreadyout"}, 32'(hreadyout0), 32'd1);
        chk({nm, " hresp"}, 32'(hresp0), 32'd0);
        chk({nm, " hrdata"}, hrdata0, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset dut0 hreadyout", 32'(hreadyout0), 32'd1);
        chk("reset dut0 hresp", 32'(hresp0), 32'd0);
        chk("reset dut0 hrdata", hrdata0, 32'd0);
        chk("reset dut1 hreadyout", 32'(hreadyout1), 32'd1);
        chk("reset dut1 hresp", 32'(hresp1), 32'd0);
        chk("reset dut1 hrdata", hrdata1, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait word write then pipelined read of the same word.
        wr(0, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, lat);
        chk("dut0 back-to-back accept latency", 32'(lat), 32'd1);
        idle();

        // Byte lane 1 and upper half-word take data from their natural lanes.
        wr(0, 3'd2, 32'h10, 32'h00000000, 1'b0);
        wr(0, 3'd0, 32'h11, 32'h0000AA00, 1'b0);
        wr(0, 3'd1, 32'h12, 32'h12340000, 1'b0);
        rd(0, 3'd2, 32'h10, 32'h1234AA00, 1'b0);
        idle();
        wr(0, 3'd2, 32'h10, 32'h00000000, 1'b0);
        wr(0, 3'd0, 32'h10, 32'hFFFFFFAA, 1'b0);
        wr(0, 3'd1, 32'h12, 32'h1234FFFF, 1'b0);
        rd(0, 3'd2, 32'h10, 32'h123400AA, 1'b0);
        idle();

        // Error responses leave the array untouched; 0x1000 would alias word 0 if unchecked.
        wr(0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
        rd(0, 3'd2, 32'h1000, 32'h0, 1'b1);
        rd(0, 3'd1, 32'h3, 32'h0, 1'b1);
        wr(0, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1);
        wr(0, 3'd1, 32'h11, 32'hFFFFFFFF, 1'b1);
        wr(0, 3'd2, 32'h12, 32'hFFFFFFFF, 1'b1);
        wr(0, 3'd2, 32'h1000, 32'hFFFFFFFF, 1'b1);
        rd(0, 3'd2, 32'h0, 32'h0BADF00D, 1'b0);
        rd(0, 3'd2, 32'h10, 32'h123400AA, 1'b0);
        idle();

        // Last word in range, then read-after-write in consecutive cycles.
        wr(0, 3'd2, 32'hFFC, 32'hCAFEF00D, 1'b0);
        rd(0, 3'd2, 32'hFFC, 32'hCAFEF00D, 1'b0);
        wr(0, 3'd2, 32'h20, 32'h11111111, 1'b0);
        rd(0, 3'd2, 32'h20, 32'h11111111, 1'b0);
        idle();

        noacc("hsel low", 1'b0, 2'b10, 1'b1, 32'h20, 32'h22222222);
        noacc("busy", 1'b1, 2'b01, 1'b1, 32'h20, 32'h33333333);
        noacc("hready low", 1'b1, 2'b10, 1'b0, 32'h20, 32'h44444444);
        rd(0, 3'd2, 32'h20, 32'h11111111, 1'b0);
        idle();

        // Two wait states: each data phase lasts three cycles, next address waits for hready.
        wr(1, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0);
        wr(1, 3'd2, 32'h4, 32'h5A5A5A5A, 1'b0);
        rd(1, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0);
        xfer(1, 1'b0, 3'd2, 32'h4, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b1, lat);
        chk("dut1 back-to-back accept latency", 32'(lat), 32'd3);
        idle();
        rd(1, 3'd2, 32'h1000, 32'h0, 1'b1);
        idle();

        // Reset during the wait of a write abandons it.
        wr(1, 3'd2, 32'h40, 32'h55555555, 1'b0);
        idle();
        xfer(1, 1'b1, 3'd2, 32'h40, 32'h99999999, 1'b0, 32'h0, 1'b0, lat);
        hsel1 = 1'b0; htrans = 2'b00;
        @(negedge clk);
        chk("dut1 stalled before reset", 32'(hreadyout1), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid-reset dut1 hreadyout", 32'(hreadyout1), 32'd1);
        chk("mid-reset dut1 hresp", 32'(hresp1), 32'd0);
        chk("mid-reset dut1 hrdata", hrdata1, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        rd(1, 3'd2, 32'h40, 32'h55555555, 1'b0);
        idle();

        chk("dut0 unconsumed expectations", 32'(q0.size()), 32'd0);
        chk("dut1 unconsumed expectations", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
